// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite single-port memory slave with byte-lane writes and optional wait states.
// Optional feature: define AHB_MEM_ERR_EN to enable the two-cycle ERROR response
// for illegal transfers. Without it, illegal accesses are coerced into legal ones.
// The data phase is a three-process FSM (IDLE / DATA / ERR1 / ERR2).
// Reads use a registered memory port. Read-after-write on the same edge is
// bypassed per byte lane.
module ahb_lite_mem_slave #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LANES = DATA_W / 8;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
`ifdef AHB_MEM_ERR_EN
    ,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
`endif
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   word_reg;
  logic               write_reg;
  logic [LANES-1:0]   lanes_reg;

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];
  logic [DATA_W-1:0]  rd_raw_reg;
  logic [DATA_W-1:0]  fwd_data_reg;
  logic [LANES-1:0]   fwd_mask_reg;
  logic [DATA_W-1:0]  rd_word;

  logic               accept;
  logic               done;
  logic               wr_en;
  logic [IDX_W-1:0]   addr_idx;
  logic [LANES-1:0]   lane_mask;
  state_t             target_state;
  logic               unused_ok;

  // A transfer starts only on a selected NONSEQ/SEQ beat while the bus is ready.
  assign accept   = HREADY && HSEL && HTRANS[1];
  assign done     = (state_reg == ST_DATA) && (cnt_reg == '0);
  assign wr_en    = done && write_reg && !HRESET;
  // The low index bits double as the modulo-DEPTH wrap when range checking is off.
  assign addr_idx = HADDR[IDX_W+1:2];

  // Little-endian lane selection. Misaligned halfwords fall back to their aligned half.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [1:0] LANE_ID = 2'(gi);
    assign lane_mask[gi] = (HSIZE == 3'd0) ? (HADDR[1:0] == LANE_ID) :
                           (HSIZE == 3'd1) ? (HADDR[1] == LANE_ID[1]) : 1'b1;
    assign rd_word[gi*8 +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[gi*8 +: 8]
                                                 : rd_raw_reg[gi*8 +: 8];
  end

`ifdef AHB_MEM_ERR_EN
  logic size_bad;
  logic misaligned;
  logic addr_oor;
  assign size_bad     = HSIZE > 3'd2;
  assign misaligned   = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign addr_oor     = (HADDR >> (IDX_W + 2)) != '0;
  assign target_state = (size_bad || misaligned || addr_oor) ? ST_ERR1 : ST_DATA;
`else
  assign target_state = ST_DATA;
`endif

  // Burst type and the BUSY/SEQ distinction carry no meaning for single-beat handling.
  assign unused_ok = ^{HBURST, HTRANS[0], HADDR};

  // State register: phase, wait counter and the captured address-phase controls.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
      write_reg <= 1'b0;
      lanes_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        word_reg  <= addr_idx;
        write_reg <= HWRITE;
        lanes_reg <= lane_mask;
      end
    end
  end

  // Next state: every ready cycle either launches the next beat or falls back to IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
    case (state_reg)
      ST_IDLE, ST_DATA: begin
        if (HREADY) begin
          state_next = accept ? target_state : ST_IDLE;
        end
      end
`ifdef AHB_MEM_ERR_EN
      ST_ERR1: state_next = ST_ERR2;
      ST_ERR2: state_next = accept ? target_state : ST_IDLE;
`endif
      default: state_next = ST_IDLE;
    endcase
    if (accept && (target_state == ST_DATA)) begin
      cnt_next = WAIT_LOAD;
    end
  end

  // Outputs: HREADY low while waiting or in the first error cycle; read data only at completion.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (state_reg)
      ST_DATA: begin
        HREADY = (cnt_reg == '0);
        if ((cnt_reg == '0) && !write_reg) begin
          HRDATA = rd_word;
        end
      end
`ifdef AHB_MEM_ERR_EN
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
`endif
      default: ;
    endcase
  end

  // Memory port: masked write at completion; read at accept with same-edge write bypass.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (lanes_reg[b]) begin
          mem[word_reg][b*8 +: 8] <= HWDATA[b*8 +: 8];
        end
      end
    end
    if (accept) begin
      rd_raw_reg   <= mem[addr_idx];
      fwd_mask_reg <= (wr_en && (word_reg == addr_idx)) ? lanes_reg : '0;
      fwd_data_reg <= HWDATA;
    end
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 16: HADDR width in bits.
REQ-002 Parameter DATA_W, default 32: HWDATA/HRDATA width; only 32 is supported.
REQ-003 Parameter DEPTH_WORDS, default 1024: number of 32-bit memory words; power of two, at most 2^(ADDR_W-2).
REQ-004 Parameter WAIT_STATES, default 0, range 0..7: number of HREADY-low cycles inserted in every OKAY data phase.
REQ-005 Port HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port HRESET, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Ports HSEL (input, 1), HADDR (input, ADDR_W), HWRITE (input, 1), HSIZE (input, 3), HBURST (input, 3), HTRANS (input, 2), HWDATA (input, 32): AHB-Lite master-side signals.
REQ-008 Ports HRDATA (output, 32), HREADY (output, 1), HRESP (output, 1): AHB-Lite slave-side signals. HREADY is also the block's own accept qualifier, for single-slave systems.

Function
REQ-009 Address phase accepted at an edge where HREADY=1, HSEL=1 and HTRANS is NONSEQ(10) or SEQ(11). Captured at that edge: HADDR, HWRITE, HSIZE.
REQ-010 HTRANS IDLE(00) or BUSY(01), or HSEL=0: no transfer; block stays in or returns to IDLE, HREADY=1, HRESP=0.
REQ-011 HBURST is ignored; each beat is an independent single transfer.
REQ-012 FSM states are IDLE, DATA, ERR1, ERR2.
REQ-013 On an accepted address phase, the next state is DATA if the transfer is legal; otherwise it is ERR1.
REQ-014 Illegal transfer: HSIZE>2, or address misaligned for HSIZE, or word index HADDR[ADDR_W-1:2] >= DEPTH_WORDS.
REQ-015 DATA entry loads a wait counter with WAIT_STATES. HREADY=0 while the counter is nonzero; the counter decrements each cycle. HREADY=1 when it reaches zero; that is the completion cycle.
REQ-016 Data phase lasts WAIT_STATES+1 cycles.
REQ-017 Write completion: at the completion edge, HWDATA is written to mem[word]. Only byte lanes selected by HSIZE/HADDR[1:0] are written, little-endian.
REQ-018 Read completion: HRDATA = mem[word], full 32-bit word, during the completion cycle. HRDATA = 0 in every other cycle.
REQ-019 A read whose address phase coincides with a write's completion cycle returns the newly written data.
REQ-020 A new accepted address phase in the completion cycle re-enters DATA (or ERR1) with no idle gap. Otherwise the next state is IDLE.
REQ-021 ERR1: HREADY=0, HRESP=1. The next state is always ERR2.
REQ-022 ERR2: HREADY=1, HRESP=1. An address phase may be accepted here under the REQ-009 rules. No memory write ever occurs for an errored transfer.
REQ-023 HRESP=0 in IDLE and DATA.

Reset
REQ-024 While HRESET=1: state=IDLE, wait counter=0, HREADY=1, HRESP=0, HRDATA=0.
REQ-025 Memory contents are not reset.
REQ-026 HRESET asserted mid-data-phase aborts the transfer. No pending write is committed.
REQ-027 First address phase is accepted at the first edge after HRESET deasserts.

Configuration
REQ-028 Macro AHB_MEM_ERR_EN defined: error detection per REQ-014 and REQ-021/022 is present.
REQ-029 Macro AHB_MEM_ERR_EN undefined: ERR1/ERR2 are absent and HRESP is tied 0. Out-of-range word index wraps modulo DEPTH_WORDS. HSIZE>2 is treated as word. Misalignment is ignored; the lane mask uses the aligned word.

Verification
REQ-030 WAIT_STATES=0: write 0xDEADBEEF at 0x0010, then read 0x0010 back-to-back. HREADY stays 1. HRDATA=0xDEADBEEF in the read data cycle.
REQ-031 WAIT_STATES=3: read 0x0010. HREADY is low exactly 3 cycles, then high with HRDATA=0xDEADBEEF.
REQ-032 Byte write 0xAA at 0x0012 (HSIZE=0), then word read at 0x0010. Result is 0xDEAABEEF.
REQ-033 With AHB_MEM_ERR_EN and DEPTH_WORDS=1024: write to 0x1000. Response is HREADY=0/HRESP=1, then HREADY=1/HRESP=1. Word 0 is unchanged on readback.
REQ-034 Halfword access at 0x0011 with AHB_MEM_ERR_EN produces the two-cycle ERROR. Without the macro, the same access completes OKAY.
REQ-035 Assert HRESET during the 2nd wait cycle of a write of 0x12345678 to 0x0020. Outputs are immediately HREADY=1/HRESP=0. A subsequent read of 0x0020 returns the prior contents.
